// File: rtl/ext_com_rx.sv
// ext_com_rx: serial frame receiver for the board-to-board link.
// Recovers bytes, acks good frames and counts them for the display.
module ext_com_rx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int DATA_W       = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_in,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              ack_out,
    output logic              frame_err,
    output logic [7:0]        rx_count,
    output logic [2:0]        state_rx
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam int BW = $clog2(DATA_W + 1);

    localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] ACK_END  = CW'(CLKS_PER_BIT);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_ACK   = 3'd4,
        S_BREAK = 3'd5
    } state_t;

    state_t            state, state_n;
    logic              sync1, rx_s;
    logic [CW-1:0]     cyc, cyc_n;
    logic [BW-1:0]     bits, bits_n;
    logic [DATA_W-1:0] shift, shift_n;
    logic [DATA_W-1:0] data_n;
    logic [7:0]        count_n;
    logic              valid_n, err_n, ack_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= rx_in;
            rx_s  <= sync1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            cyc       <= '0;
            bits      <= '0;
            shift     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            ack_out   <= 1'b0;
            rx_count  <= '0;
        end else begin
            state     <= state_n;
            cyc       <= cyc_n;
            bits      <= bits_n;
            shift     <= shift_n;
            rx_data   <= data_n;
            rx_valid  <= valid_n;
            frame_err <= err_n;
            ack_out   <= ack_n;
            rx_count  <= count_n;
        end
    end

    always_comb begin
        state_n = state;
        cyc_n   = cyc;
        bits_n  = bits;
        shift_n = shift;
        data_n  = rx_data;
        count_n = rx_count;
        valid_n = 1'b0;
        err_n   = 1'b0;
        ack_n   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (!rx_s) begin
                    state_n = S_START;
                    cyc_n   = '0;
                end
            end
            S_START: begin
                if (cyc == HALF_END) begin
                    cyc_n   = '0;
                    bits_n  = '0;
                    state_n = rx_s ? S_IDLE : S_DATA;
                end else begin
                    cyc_n = cyc + 1'b1;
                end
            end
            S_DATA: begin
                if (cyc == BIT_END) begin
                    cyc_n   = '0;
                    shift_n = {rx_s, shift[DATA_W-1:1]};
                    bits_n  = bits + 1'b1;
                    if (bits == BIT_LAST) begin
                        state_n = S_STOP;
                    end
                end else begin
                    cyc_n = cyc + 1'b1;
                end
            end
            S_STOP: begin
                if (cyc == BIT_END) begin
                    cyc_n = '0;
                    if (rx_s) begin
                        data_n  = shift;
                        valid_n = 1'b1;
                        count_n = rx_count + 8'd1;
                        state_n = S_ACK;
                    end else begin
                        err_n   = 1'b1;
                        state_n = S_BREAK;
                    end
                end else begin
                    cyc_n = cyc + 1'b1;
                end
            end
            // First ACK cycle carries rx_valid; ack_out follows for one bit.
            S_ACK: begin
                if (cyc == ACK_END) begin
                    cyc_n   = '0;
                    state_n = S_IDLE;
                end else begin
                    cyc_n = cyc + 1'b1;
                    ack_n = 1'b1;
                end
            end
            S_BREAK: begin
                if (rx_s) begin
                    state_n = S_IDLE;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    assign state_rx = state;

endmodule

// File: tb/tb_ext_com_rx.sv
// tb_ext_com_rx: directed bench for ext_com_rx.
// Frames driven on negedge, outputs observed on negedge.
module tb_ext_com_rx;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_in;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       ack_out;
    logic       frame_err;
    logic [7:0] rx_count;
    logic [2:0] state_rx;

    int n_vec = 0;
    int n_bad = 0;

    int pcnt = 0;
    int start_cyc = 0;
    int valid_cyc = 0;
    int n_valid = 0;
    int n_ferr = 0;
    int n_ackp = 0;
    int n_ackc = 0;
    int bad_run = 0;
    int run = 0;
    int excl = 0;
    int busy = 0;
    logic [2:0] slog [0:4095];
    int log_n = 0;
    logic [2:0] prev_st = 3'd0;

    ext_com_rx #(.CLKS_PER_BIT(CPB), .DATA_W(8)) dut (
        .clk(clk),
        .reset(rst_n),
        .rx_in(rx_in),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .ack_out(ack_out),
        .frame_err(frame_err),
        .rx_count(rx_count),
        .state_rx(state_rx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) pcnt <= pcnt + 1;

    always @(negedge clk) begin
        if (rx_valid) begin
            n_valid++;
            valid_cyc = pcnt;
        end
        if (frame_err) n_ferr++;
        if (rx_valid && frame_err) excl++;
        if (state_rx != 3'd0) busy++;
        if (ack_out) begin
            run++;
            n_ackc++;
        end else if (run != 0) begin
            if (run != CPB) bad_run++;
            n_ackp++;
            run = 0;
        end
        if (state_rx != prev_st && log_n < 4096) begin
            slog[log_n] = state_rx;
            log_n++;
        end
        prev_st = state_rx;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rx_in = 1'b1;
        end
    endtask

    task automatic send(input logic [7:0] d, input logic stop,
                        input int abort_bit);
        @(negedge clk);
        rx_in = 1'b0;
        start_cyc = pcnt;
        repeat (CPB - 1) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            rx_in = d[i];
            if (i == abort_bit) begin
                repeat (2) @(negedge clk);
                rst_n = 1'b0;
                return;
            end
            repeat (CPB - 1) @(negedge clk);
        end
        @(negedge clk);
        rx_in = stop;
        repeat (CPB - 1) @(negedge clk);
        if (stop) begin
            @(negedge clk);
            rx_in = 1'b1;
        end
    endtask

    int s, v0, a0, c0, f0, lat;

    initial begin
        rst_n = 1'b0;
        rx_in = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_data", rx_data, 0);
        check("rst_valid", rx_valid, 0);
        check("rst_ack", ack_out, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_count", rx_count, 0);
        check("rst_state", state_rx, 0);
        rst_n = 1'b1;
        v0 = n_valid; a0 = n_ackc; f0 = n_ferr; c0 = busy;
        idle(100);
        check("idle_valid", n_valid - v0, 0);
        check("idle_ack", n_ackc - a0, 0);
        check("idle_ferr", n_ferr - f0, 0);
        check("idle_busy", busy - c0, 0);
        check("idle_count", rx_count, 0);

        s = log_n; v0 = n_valid; a0 = n_ackc; c0 = n_ackp;
        send(8'hA5, 1'b1, -1);
        idle(12);
        lat = valid_cyc - start_cyc;
        check("a5_data", rx_data, 8'hA5);
        check("a5_count", rx_count, 1);
        check("a5_valid", n_valid - v0, 1);
        check("a5_ackcyc", n_ackc - a0, CPB);
        check("a5_ackp", n_ackp - c0, 1);
        check("a5_lat", (lat >= 39 && lat <= 41), 1);
        check("a5_st0", slog[s], 1);
        check("a5_st1", slog[s+1], 2);
        check("a5_st2", slog[s+2], 3);
        check("a5_st3", slog[s+3], 4);
        check("a5_st4", slog[s+4], 0);
        check("a5_nst", log_n - s, 5);

        s = log_n; v0 = n_valid;
        @(negedge clk);
        rx_in = 1'b0;
        idle(10);
        check("gl_st0", slog[s], 1);
        check("gl_st1", slog[s+1], 0);
        check("gl_nst", log_n - s, 2);
        check("gl_valid", n_valid - v0, 0);
        check("gl_count", rx_count, 1);

        f0 = n_ferr; v0 = n_valid;
        send(8'h3C, 1'b0, -1);
        repeat (20) @(negedge clk);
        check("fe_state", state_rx, 5);
        check("fe_pulse", n_ferr - f0, 1);
        check("fe_data", rx_data, 8'hA5);
        check("fe_count", rx_count, 1);
        check("fe_valid", n_valid - v0, 0);
        idle(12);
        check("fe_idle", state_rx, 0);
        check("fe_pulse2", n_ferr - f0, 1);
        send(8'h55, 1'b1, -1);
        idle(12);
        check("x55_data", rx_data, 8'h55);
        check("x55_count", rx_count, 2);

        send(8'hF0, 1'b1, 4);
        @(negedge clk);
        check("mr_ack", ack_out, 0);
        check("mr_state", state_rx, 0);
        check("mr_count", rx_count, 0);
        check("mr_data", rx_data, 0);
        rx_in = 1'b1;
        rst_n = 1'b1;
        idle(12);
        v0 = n_valid;
        send(8'h0F, 1'b1, -1);
        idle(12);
        check("mr_data2", rx_data, 8'h0F);
        check("mr_count2", rx_count, 1);
        check("mr_valid", n_valid - v0, 1);

        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(4);
        v0 = n_valid; c0 = n_ackp;
        for (int i = 0; i < 255; i++) begin
            send(8'(i), 1'b1, -1);
            idle(12);
        end
        check("wr_c255", rx_count, 255);
        check("wr_d254", rx_data, 8'hFE);
        send(8'hFF, 1'b1, -1);
        idle(12);
        check("wr_count", rx_count, 0);
        check("wr_data", rx_data, 8'hFF);
        check("wr_valid", n_valid - v0, 256);
        check("wr_ackp", n_ackp - c0, 256);
        check("ack_runs", bad_run, 0);
        check("excl", excl, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
